// File: rtl/vram_cpu_arbiter.sv
// vram_cpu_arbiter
//
// Shares one byte-wide RAM between the video fetch engine and the CPU.
// A free-running 2-bit phase counter divides time into four-clock slots.
// Phase 0 carries the video fetch (two clocks: VID_A, VID_D over ph0/ph1).
// CPU accesses (CPU_A, CPU_D) start wherever the CPU window is open.
//
// Slot decisions are made in the clock *before* the phase they occupy.
// They therefore compare against the upcoming phase (ph_next). A video
// fetch requested for phase 0 runs its address cycle during ph0. A CPU
// access granted for phase 2 has CPU_A during ph2.
//
// Optional feature (compile-time macro):
//   ARB_BORDER_CONTENTION_EN - when defined, the CPU window opens only at
//     phase 2 even outside the display window. By default the window is
//     open at every phase while video_active is low.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   video_active        display-window flag
//   video_req           video fetch wanted in the coming slot
//   vramaddr            video fetch address
//   mreq_n, rd_n, wr_n  CPU memory strobes (active-low)
//   cpuramaddr          CPU RAM address
//   data_from_cpu       CPU write data
//   data_from_ram       RAM read data
//   ramaddr             address driven to RAM
//   ram_we_n            RAM write strobe (active-low)
//   data_to_ram         RAM write data
//   cpu_rdata           latched CPU read data
//   video_data          latched video byte
//   video_valid         one-clock strobe: video_data just updated
//   video_miss          one-clock strobe: a video slot was lost to the CPU
//   wait_n              CPU wait request (active-low)
//   asic_is_using_ram   high while video owns the RAM
module vram_cpu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        video_active,
  input  logic        video_req,
  input  logic [18:0] vramaddr,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [18:0] cpuramaddr,
  input  logic [7:0]  data_from_cpu,
  input  logic [7:0]  data_from_ram,
  output logic [18:0] ramaddr,
  output logic        ram_we_n,
  output logic [7:0]  data_to_ram,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  video_data,
  output logic        video_valid,
  output logic        video_miss,
  output logic        wait_n,
  output logic        asic_is_using_ram
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VID_A = 3'd1,
    VID_D = 3'd2,
    CPU_A = 3'd3,
    CPU_D = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ph_reg;
  logic [1:0]  ph_next;
  logic        served_reg;
  logic [7:0]  cpu_rdata_reg;
  logic [7:0]  video_data_reg;
  logic        video_valid_reg;
  logic        video_miss_reg;

  logic        pending;
  logic        slot_hit;
  logic        cpu_window;
  logic        in_cpu;
  logic        in_vid;

  assign ph_next = ph_reg + 2'd1;

  // Video wants the phase-0 slot that starts on the next edge.
  assign slot_hit = (ph_next == 2'd0) && video_active && video_req;

`ifdef ARB_BORDER_CONTENTION_EN
  assign cpu_window = (ph_next == 2'd2);
`else
  assign cpu_window = video_active ? (ph_next == 2'd2) : 1'b1;
`endif

  // served blocks a second access while the same mreq_n assertion is held.
  assign pending = !mreq_n && (!rd_n || !wr_n) && !served_reg;

  assign in_cpu = (state_reg == CPU_A) || (state_reg == CPU_D);
  assign in_vid = (state_reg == VID_A) || (state_reg == VID_D);

  // State register and data latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_reg          <= 2'd0;
      state_reg       <= IDLE;
      served_reg      <= 1'b0;
      cpu_rdata_reg   <= 8'h00;
      video_data_reg  <= 8'h00;
      video_valid_reg <= 1'b0;
      video_miss_reg  <= 1'b0;
    end else begin
      ph_reg    <= ph_next;
      state_reg <= state_next;

      // Releasing mreq_n re-arms the CPU for its next access.
      if (mreq_n)
        served_reg <= 1'b0;
      else if (state_reg == CPU_D)
        served_reg <= 1'b1;

      video_valid_reg <= (state_reg == VID_D);
      if (state_reg == VID_D)
        video_data_reg <= data_from_ram;

      if ((state_reg == CPU_D) && !rd_n)
        cpu_rdata_reg <= data_from_ram;

      // A CPU access that overlaps the video slot wins; the slot is dropped.
      video_miss_reg <= slot_hit && in_cpu;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (slot_hit)
          state_next = VID_A;
        else if (pending && cpu_window)
          state_next = CPU_A;
      end
      VID_A:   state_next = VID_D;
      VID_D:   state_next = IDLE;
      CPU_A:   state_next = CPU_D;
      CPU_D:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-side outputs are decoded from the state register directly.
  // Reset therefore releases ram_we_n without waiting for a clock.
  always_comb begin
    ramaddr           = cpuramaddr;
    ram_we_n          = 1'b1;
    asic_is_using_ram = 1'b0;
    if (in_vid) begin
      ramaddr           = vramaddr;
      asic_is_using_ram = 1'b1;
    end
    if ((state_reg == CPU_D) && !wr_n)
      ram_we_n = 1'b0;
  end

  assign data_to_ram = data_from_cpu;
  assign wait_n      = !pending;
  assign cpu_rdata   = cpu_rdata_reg;
  assign video_data  = video_data_reg;
  assign video_valid = video_valid_reg;
  assign video_miss  = video_miss_reg;

endmodule

// File: tb/tb_vram_cpu_arbiter.sv
// Testbench for vram_cpu_arbiter.
// A slot-level model tracks which master owns the RAM and for how many more
// clocks. Every cycle, the DUT outputs are compared against that model.
// Literal expectations pin the directed scenarios.
module tb_vram_cpu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        video_active = 1'b0;
  logic        video_req = 1'b0;
  logic [18:0] vramaddr = 19'h0;
  logic        mreq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [18:0] cpuramaddr = 19'h0;
  logic [7:0]  data_from_cpu = 8'h0;
  logic [7:0]  data_from_ram = 8'h0;
  logic [18:0] ramaddr;
  logic        ram_we_n;
  logic [7:0]  data_to_ram;
  logic [7:0]  cpu_rdata;
  logic [7:0]  video_data;
  logic        video_valid;
  logic        video_miss;
  logic        wait_n;
  logic        asic_is_using_ram;

  always #5 clk = ~clk;

  vram_cpu_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .video_active      (video_active),
    .video_req         (video_req),
    .vramaddr          (vramaddr),
    .mreq_n            (mreq_n),
    .rd_n              (rd_n),
    .wr_n              (wr_n),
    .cpuramaddr        (cpuramaddr),
    .data_from_cpu     (data_from_cpu),
    .data_from_ram     (data_from_ram),
    .ramaddr           (ramaddr),
    .ram_we_n          (ram_we_n),
    .data_to_ram       (data_to_ram),
    .cpu_rdata         (cpu_rdata),
    .video_data        (video_data),
    .video_valid       (video_valid),
    .video_miss        (video_miss),
    .wait_n            (wait_n),
    .asic_is_using_ram (asic_is_using_ram)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: m_vid / m_cpu = clocks already spent in an access (0 = none).
  int         m_ph;
  int         m_vid;
  int         m_cpu;
  bit         m_served;
  bit         m_vvalid;
  bit         m_miss;
  logic [7:0] m_vdata;
  logic [7:0] m_rdata;

  function automatic bit m_pending();
    return !mreq_n && (!rd_n || !wr_n) && !m_served;
  endfunction

  function automatic bit m_window(int nph);
`ifdef ARB_BORDER_CONTENTION_EN
    return nph == 2;
`else
    return video_active ? (nph == 2) : 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_ph = 0; m_vid = 0; m_cpu = 0; m_served = 0;
    m_vvalid = 0; m_miss = 0; m_vdata = 8'h00; m_rdata = 8'h00;
  endtask

  task automatic model_edge();
    int nph;
    bit slot, pend, idle;
    if (rst) begin
      model_reset();
      return;
    end
    nph  = (m_ph + 1) % 4;
    slot = (nph == 0) && video_active && video_req;
    pend = m_pending();
    idle = (m_vid == 0) && (m_cpu == 0);
    m_vvalid = (m_vid == 2);
    if (m_vid == 2) m_vdata = data_from_ram;
    if (m_cpu == 2 && !rd_n) m_rdata = data_from_ram;
    m_miss = slot && (m_cpu != 0);
    if (mreq_n) m_served = 0;
    else if (m_cpu == 2) m_served = 1;
    m_vid = (m_vid == 1) ? 2 : 0;
    m_cpu = (m_cpu == 1) ? 2 : 0;
    if (idle) begin
      if (slot) m_vid = 1;
      else if (pend && m_window(nph)) m_cpu = 1;
    end
    m_ph = nph;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [18:0] exp_addr;
    exp_addr = (m_vid != 0) ? vramaddr : cpuramaddr;
    chk("ramaddr", 32'(ramaddr), 32'(exp_addr));
    chk("ram_we_n", 32'(ram_we_n), 32'(!(m_cpu == 2 && !wr_n)));
    chk("asic_is_using_ram", 32'(asic_is_using_ram), 32'(m_vid != 0));
    chk("wait_n", 32'(wait_n), 32'(!m_pending()));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    chk("video_data", 32'(video_data), 32'(m_vdata));
    chk("video_valid", 32'(video_valid), 32'(m_vvalid));
    chk("video_miss", 32'(video_miss), 32'(m_miss));
    if (m_cpu != 0) chk("data_to_ram", 32'(data_to_ram), 32'(data_from_cpu));
  endtask

  // One clock: model follows the edge, outputs are checked at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    $display("cycle ph=%0d vid=%0d cpu=%0d ramaddr=%h we_n=%b wait_n=%b",
             m_ph, m_vid, m_cpu, ramaddr, ram_we_n, wait_n);
  endtask

  task automatic goto_ph(input int p);
    for (int i = 0; i < 8 && m_ph != p; i++) step();
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset state
    @(negedge clk);
    compare_all();
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_video_data", 32'(video_data), 32'h00);
    chk("rst_asic", 32'(asic_is_using_ram), 32'd0);
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    step();
    rst = 1'b0;

    // Video fetch: address during ph0/ph1, byte valid in ph2
    goto_ph(3);
    video_active = 1'b1; video_req = 1'b1;
    vramaddr = 19'h00100; data_from_ram = 8'hAA;
    step();
    chk("vid_addr_ph0", 32'(ramaddr), 32'h00100);
    chk("vid_asic_ph0", 32'(asic_is_using_ram), 32'd1);
    step();
    chk("vid_addr_ph1", 32'(ramaddr), 32'h00100);
    video_req = 1'b0;
    step();
    chk("vid_valid_ph2", 32'(video_valid), 32'd1);
    chk("vid_data", 32'(video_data), 32'hAA);
    step();
    chk("vid_valid_ph3", 32'(video_valid), 32'd0);

    // CPU read in the display window: granted only at ph2
    goto_ph(0);
    mreq_n = 1'b0; rd_n = 1'b0; cpuramaddr = 19'h01234; data_from_ram = 8'h3C;
    #1;
    chk("rd_wait_ph0", 32'(wait_n), 32'd0);
    step();
    chk("rd_wait_ph1", 32'(wait_n), 32'd0);
    step();
    chk("rd_wait_ph2", 32'(wait_n), 32'd0);
    step();
    chk("rd_wait_ph3", 32'(wait_n), 32'd0);
    step();
    chk("rd_wait_done", 32'(wait_n), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'h3C);
    data_from_ram = 8'h00;
    // Held mreq_n: no second access
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rd_hold_wait", 32'(wait_n), 32'd1);
      chk("rd_hold_data", 32'(cpu_rdata), 32'h3C);
    end
    mreq_n = 1'b1; rd_n = 1'b1;
    step();

`ifndef ARB_BORDER_CONTENTION_EN
    // Border write at ph3; video slot at ph0 is lost to it
    video_active = 1'b0; video_req = 1'b0;
    goto_ph(2);
    mreq_n = 1'b0; wr_n = 1'b0; data_from_cpu = 8'h55; cpuramaddr = 19'h02000;
    #1;
    chk("wr_wait_req", 32'(wait_n), 32'd0);
    step();
    chk("wr_we_cpu_a", 32'(ram_we_n), 32'd1);
    chk("wr_data", 32'(data_to_ram), 32'h55);
    video_active = 1'b1; video_req = 1'b1;
    step();
    chk("wr_we_cpu_d", 32'(ram_we_n), 32'd0);
    chk("wr_miss", 32'(video_miss), 32'd1);
    chk("wr_addr", 32'(ramaddr), 32'h02000);
    video_req = 1'b0;
    step();
    chk("wr_miss_clear", 32'(video_miss), 32'd0);
    chk("wr_wait_done", 32'(wait_n), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("wr_hold_we", 32'(ram_we_n), 32'd1);
      chk("wr_hold_wait", 32'(wait_n), 32'd1);
    end
    mreq_n = 1'b1; wr_n = 1'b1;
    step();
`else
    // Border read still waits for ph2
    video_active = 1'b0; video_req = 1'b0;
    goto_ph(0);
    mreq_n = 1'b0; rd_n = 1'b0; data_from_ram = 8'h77;
    #1;
    chk("brd_wait_ph0", 32'(wait_n), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("brd_wait", 32'(wait_n), 32'd0);
    end
    step();
    chk("brd_wait_done", 32'(wait_n), 32'd1);
    chk("brd_data", 32'(cpu_rdata), 32'h77);
    mreq_n = 1'b1; rd_n = 1'b1;
    step();
`endif

    // Reset during CPU_D of a write
    video_active = 1'b0; video_req = 1'b0;
    mreq_n = 1'b0; wr_n = 1'b0; cpuramaddr = 19'h03000; data_from_cpu = 8'hA5;
    data_from_ram = 8'hEE;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (ram_we_n == 1'b0) found = 1'b1;
    end
    chk("rst_we_reached", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_async_asic", 32'(asic_is_using_ram), 32'd0);
    model_reset();
    mreq_n = 1'b1; wr_n = 1'b1;
    step();
    chk("rst_mid_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_mid_vdata", 32'(video_data), 32'h00);
    rst = 1'b0;
    step();

    // Mixed traffic
    for (int i = 0; i < 64; i++) begin
      video_active  = ((i / 16) % 2) == 0;
      video_req     = (i % 3) != 0;
      vramaddr      = 19'(i * 19'h00111);
      mreq_n        = (i % 9) >= 6;
      rd_n          = ((i / 9) % 2) == 1;
      wr_n          = ((i / 9) % 2) == 0;
      cpuramaddr    = 19'(i * 19'h00203 + 19'h40000);
      data_from_cpu = 8'(i * 3);
      data_from_ram = 8'(i * 7 + 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
